// File: rtl/famicom_bus_pkg.sv
// Shared types and constants for the Famicom cartridge bus master.
package famicom_bus_pkg;

   typedef enum logic {
      PH_LOW  = 1'b0,
      PH_HIGH = 1'b1
   } phase_t;

   localparam int M2_LOW_CLKS_DEF  = 6;
   localparam int M2_HIGH_CLKS_DEF = 6;

   localparam logic [14:0] RESET_ADDR = 15'h7FFF;

endpackage

// File: rtl/famicom_irq_sync.sv
// Two-flop synchroniser for the cartridge /IRQ line; output is the active-high level.
module famicom_irq_sync (
   input  logic clk,
   input  logic reset,
   input  logic irq,
   output logic irq_active
);

   logic [1:0] sync_q;

   // The flops carry the inverted pin so irq_active comes straight from a register.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], ~irq};
      end
   end

   assign irq_active = sync_q[1];

endmodule

// File: rtl/famicom_bus_master.sv
// Famicom CPU-side bus master: generates M2 and runs one cartridge cycle per M2 period.
// Optional IRQ synchroniser enabled by defining FAMICOM_BUS_MASTER_IRQ_SYNC_EN.
module famicom_bus_master
   import famicom_bus_pkg::*;
#(
   parameter int M2_LOW_CLKS  = M2_LOW_CLKS_DEF,
   parameter int M2_HIGH_CLKS = M2_HIGH_CLKS_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [15:0] req_addr,
   input  logic        req_rw,
   input  logic [7:0]  req_wdata,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        m2,
   output logic        romsel,
   output logic        cpu_rw,
   output logic [14:0] cpu_addr,
   output logic [7:0]  cpu_data_out,
   output logic        cpu_data_oe,
   input  logic [7:0]  cpu_data_in,
   input  logic        irq,
   output logic        irq_active
);

   if (M2_LOW_CLKS < 2) begin : g_bad_low
      $error("M2_LOW_CLKS must be at least 2");
   end
   if (M2_HIGH_CLKS < 2) begin : g_bad_high
      $error("M2_HIGH_CLKS must be at least 2");
   end

   localparam int MAX_CLKS = (M2_LOW_CLKS > M2_HIGH_CLKS) ? M2_LOW_CLKS : M2_HIGH_CLKS;
   localparam int CNT_W    = $clog2(MAX_CLKS);
   localparam logic [CNT_W-1:0] LOW_LAST  = CNT_W'(M2_LOW_CLKS - 1);
   localparam logic [CNT_W-1:0] HIGH_LAST = CNT_W'(M2_HIGH_CLKS - 1);

   phase_t           phase, phase_nxt;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             end_low, end_high, accept, ready_nxt;
   logic             active, lat_rw, lat_a15;
   logic [7:0]       lat_wdata;

   // Handshake: a request transfers on a rising clk edge where req_valid && req_ready;
   // req_ready is high only in the last clk of M2-high, so at most one transfer per bus cycle.
   always_comb begin
      phase_nxt = phase;
      cnt_nxt   = cnt + CNT_W'(1);
      end_low   = 1'b0;
      end_high  = 1'b0;
      case (phase)
         PH_LOW: if (cnt == LOW_LAST) begin
            end_low   = 1'b1;
            phase_nxt = PH_HIGH;
            cnt_nxt   = '0;
         end
         PH_HIGH: if (cnt == HIGH_LAST) begin
            end_high  = 1'b1;
            phase_nxt = PH_LOW;
            cnt_nxt   = '0;
         end
         default: ;
      endcase
      accept    = req_valid && req_ready;
      ready_nxt = (phase_nxt == PH_HIGH) && (cnt_nxt == HIGH_LAST);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         phase <= PH_LOW;
         cnt   <= '0;
      end else begin
         phase <= phase_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // Outputs change only on phase boundaries; 'active' marks a real (non-dummy) bus cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         m2           <= 1'b0;
         romsel       <= 1'b1;
         cpu_rw       <= 1'b1;
         cpu_addr     <= RESET_ADDR;
         cpu_data_out <= 8'h00;
         cpu_data_oe  <= 1'b0;
         req_ready    <= 1'b0;
         rsp_valid    <= 1'b0;
         rsp_rdata    <= 8'h00;
         active       <= 1'b0;
         lat_rw       <= 1'b1;
         lat_a15      <= 1'b0;
         lat_wdata    <= 8'h00;
      end else begin
         req_ready <= ready_nxt;
         rsp_valid <= 1'b0;
         if (end_low) begin
            m2          <= 1'b1;
            romsel      <= ~(active && lat_a15);
            cpu_data_oe <= active && !lat_rw;
            if (active && !lat_rw) cpu_data_out <= lat_wdata;
         end
         if (end_high) begin
            m2          <= 1'b0;
            romsel      <= 1'b1;
            cpu_data_oe <= 1'b0;
            rsp_valid   <= active;
            if (active && lat_rw) rsp_rdata <= cpu_data_in;
            active <= accept;
            if (accept) begin
               lat_rw    <= req_rw;
               lat_a15   <= req_addr[15];
               lat_wdata <= req_wdata;
               cpu_addr  <= req_addr[14:0];
               cpu_rw    <= req_rw;
            end else begin
               cpu_rw <= 1'b1;
            end
         end
      end
   end

`ifdef FAMICOM_BUS_MASTER_IRQ_SYNC_EN
   famicom_irq_sync u_irq_sync (
      .clk        (clk),
      .reset      (reset),
      .irq        (irq),
      .irq_active (irq_active)
   );
`else
   logic unused_irq;
   assign unused_irq = irq;
   assign irq_active = 1'b0;
`endif

endmodule

// File: tb/tb_famicom_bus_master.sv
// Bench for famicom_bus_master: cycle-position reference model, vector table and corner sequences.
module tb_famicom_bus_master;

   localparam int L = 6;
   localparam int H = 6;
   localparam int P = L + H;

   logic        clk = 1'b0;
   logic        reset, req_valid, req_ready, req_rw, rsp_valid;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata, rsp_rdata, cpu_data_out, cpu_data_in;
   logic        m2, romsel, cpu_rw, cpu_data_oe, irq, irq_active;
   logic [14:0] cpu_addr;

   always #5 clk = ~clk;

   famicom_bus_master #(.M2_LOW_CLKS(L), .M2_HIGH_CLKS(H)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_addr(req_addr), .req_rw(req_rw), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .m2(m2), .romsel(romsel),
      .cpu_rw(cpu_rw), .cpu_addr(cpu_addr), .cpu_data_out(cpu_data_out),
      .cpu_data_oe(cpu_data_oe), .cpu_data_in(cpu_data_in), .irq(irq),
      .irq_active(irq_active)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc_n = 0;

   // Reference model: position within the 12-clk bus cycle plus the transaction owning it.
   int          m_pos;
   logic        m_valid, m_rw, m_a15, m_rsp;
   logic [7:0]  m_wdata, m_dout, m_rdata;
   logic [14:0] m_addr;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_n);
      end
   endtask

   task automatic model_reset();
      m_pos   = 0;
      m_valid = 1'b0;
      m_rw    = 1'b1;
      m_a15   = 1'b0;
      m_rsp   = 1'b0;
      m_wdata = 8'h00;
      m_dout  = 8'h00;
      m_rdata = 8'h00;
      m_addr  = 15'h7FFF;
   endtask

   task automatic check_outputs();
      logic hi;
      hi = (m_pos >= L);
      chk("m2", m2, hi);
      chk("req_ready", req_ready, m_pos == P - 1);
      chk("cpu_addr", cpu_addr, m_addr);
      chk("cpu_rw", cpu_rw, m_valid ? m_rw : 1'b1);
      chk("romsel", romsel, !(hi && m_valid && m_a15));
      chk("cpu_data_oe", cpu_data_oe, hi && m_valid && !m_rw);
      chk("cpu_data_out", cpu_data_out, m_dout);
      chk("rsp_valid", rsp_valid, m_rsp);
      chk("rsp_rdata", rsp_rdata, m_rdata);
   endtask

   task automatic model_advance();
      if (reset) begin
         model_reset();
         return;
      end
      m_rsp = 1'b0;
      if (m_pos == P - 1) begin
         m_rsp = m_valid;
         if (m_valid && m_rw) m_rdata = cpu_data_in;
         m_valid = req_valid;
         if (req_valid) begin
            m_rw    = req_rw;
            m_a15   = req_addr[15];
            m_wdata = req_wdata;
            m_addr  = req_addr[14:0];
         end
         m_pos = 0;
      end else begin
         if (m_pos == L - 1 && m_valid && !m_rw) m_dout = m_wdata;
         m_pos++;
      end
   endtask

   task automatic step();
      check_outputs();
      model_advance();
      @(negedge clk);
      cyc_n++;
   endtask

   task automatic idle_to_slot();
      req_valid = 1'b0;
      for (int i = 0; i < P && m_pos != P - 1; i++) step();
   endtask

   typedef struct {
      logic [15:0] addr;
      logic        rw;
      logic [7:0]  wdata;
      logic [7:0]  din;
      logic [14:0] e_addr;
      int          e_oe;
      int          e_rs_low;
      logic [7:0]  e_rdata;
   } vec_t;

   vec_t tbl[5];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int hi_cnt, r1, r2, rsp_k, oe_cnt, rs_low, acc, rv, dummy_bad;
      logic prev_m2;
      int rsp_t[$];

      tbl[0] = '{16'h8123, 1'b1, 8'h00, 8'hA5, 15'h0123, 0, 6, 8'hA5};
      tbl[1] = '{16'h6000, 1'b0, 8'h3C, 8'h77, 15'h6000, 6, 0, 8'hA5};
      tbl[2] = '{16'h8000, 1'b0, 8'hFF, 8'h00, 15'h0000, 6, 6, 8'hA5};
      tbl[3] = '{16'hFFFC, 1'b1, 8'h00, 8'h5A, 15'h7FFC, 0, 6, 8'h5A};
      tbl[4] = '{16'h0000, 1'b1, 8'h00, 8'h11, 15'h0000, 0, 0, 8'h11};

      reset = 1'b1; req_valid = 1'b0; req_addr = 16'h0; req_rw = 1'b1;
      req_wdata = 8'h0; cpu_data_in = 8'h0; irq = 1'b1;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      repeat (3) step();
      chk("rst_irq_active", irq_active, 0);
      reset = 1'b0;

      // Idle after reset: M2 period and duty
      hi_cnt = 0; r1 = -1; r2 = -1; prev_m2 = m2;
      for (int i = 0; i < 2 * P + 1; i++) begin
         if (i < 2 * P && m2) hi_cnt++;
         if (m2 && !prev_m2) begin
            if (r1 < 0) r1 = i; else if (r2 < 0) r2 = i;
         end
         prev_m2 = m2;
         step();
      end
      chk("idle_m2_high_clks", hi_cnt, P);
      chk("idle_m2_period", r2 - r1, P);

      // Vector table: one request per entry, observed for 13 clks after acceptance
      foreach (tbl[v]) begin
         idle_to_slot();
         req_valid = 1'b1; req_addr = tbl[v].addr; req_rw = tbl[v].rw;
         req_wdata = tbl[v].wdata; cpu_data_in = tbl[v].din;
         step();
         req_valid = 1'b0;
         rsp_k = 0; oe_cnt = 0; rs_low = 0;
         for (int k = 1; k <= 13; k++) begin
            req_addr = 16'($urandom); req_wdata = 8'($urandom); req_rw = 1'($urandom);
            if (k == 1) begin
               chk("tbl_addr", cpu_addr, tbl[v].e_addr);
               chk("tbl_rw", cpu_rw, tbl[v].rw);
            end
            if (rsp_valid && rsp_k == 0) rsp_k = k;
            if (cpu_data_oe) begin
               oe_cnt++;
               chk("tbl_dout", cpu_data_out, tbl[v].wdata);
            end
            if (!romsel) rs_low++;
            if (k < 13) step();
         end
         chk("tbl_rsp_at", rsp_k, 13);
         chk("tbl_oe_clks", oe_cnt, tbl[v].e_oe);
         chk("tbl_romsel_low", rs_low, tbl[v].e_rs_low);
         chk("tbl_rdata", rsp_rdata, tbl[v].e_rdata);
         step();
      end

      // Back-to-back reads with req_valid held high
      idle_to_slot();
      req_valid = 1'b1; req_rw = 1'b1; acc = 0;
      for (int s = 0; s < 3 * P + 14; s++) begin
         if (m_pos == P - 1) begin
            if (acc < 3) begin
               req_addr = 16'h8000 + 16'(acc);
               cpu_data_in = 8'h10 + 8'(acc);
               acc++;
            end else begin
               req_valid = 1'b0;
            end
         end
         step();
         if (rsp_valid) rsp_t.push_back(cyc_n);
      end
      chk("b2b_count", rsp_t.size(), 3);
      if (rsp_t.size() >= 3) begin
         chk("b2b_gap1", rsp_t[1] - rsp_t[0], P);
         chk("b2b_gap2", rsp_t[2] - rsp_t[1], P);
      end

      // Reset during clk 3 of the HIGH phase of a write
      idle_to_slot();
      req_valid = 1'b1; req_rw = 1'b0; req_addr = 16'h6000; req_wdata = 8'h3C;
      step();
      req_valid = 1'b0;
      for (int i = 0; i < P && m_pos != L + 3; i++) step();
      chk("mr_oe_before", cpu_data_oe, 1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      chk("mr_m2", m2, 0);
      chk("mr_oe", cpu_data_oe, 0);
      rv = 0; dummy_bad = 0;
      repeat (P + 1) begin
         if (rsp_valid) rv++;
         if (!romsel || !cpu_rw || cpu_data_oe) dummy_bad++;
         step();
      end
      chk("mr_no_rsp", rv, 0);
      chk("mr_dummy", dummy_bad, 0);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         req_valid   = 1'($urandom_range(0, 1));
         req_addr    = 16'($urandom);
         req_rw      = 1'($urandom_range(0, 1));
         req_wdata   = 8'($urandom);
         cpu_data_in = 8'($urandom);
         reset       = ($urandom_range(0, 149) == 0);
         step();
      end
      reset = 1'b0; req_valid = 1'b0;
      step();

`ifdef FAMICOM_BUS_MASTER_IRQ_SYNC_EN
      irq = 1'b1;
      repeat (3) step();
      chk("irq_idle", irq_active, 0);
      irq = 1'b0;
      step();
      chk("irq_1clk", irq_active, 0);
      step();
      chk("irq_2clk", irq_active, 1);
      irq = 1'b1;
      repeat (2) step();
      chk("irq_release", irq_active, 0);
`else
      irq = 1'b0;
      repeat (4) step();
      chk("irq_off", irq_active, 0);
      irq = 1'b1;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/famicom_bus_master.md
FAMICOM_BUS_MASTER -- requirements
Module: famicom_bus_master

Interface
REQ-001 SHALL have parameter M2_LOW_CLKS, default 6, the number of clk cycles per M2-low phase (minimum 2).
REQ-002 SHALL have parameter M2_HIGH_CLKS, default 6, the number of clk cycles per M2-high phase (minimum 2).
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 SHALL have ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- req_valid  in  1  bus request present
- req_ready  out  1  request accepted this clk
- req_addr  in  16  CPU address
- req_rw  in  1  1=read, 0=write
- req_wdata  in  8  write data
- rsp_valid  out  1  one-clk completion pulse
- rsp_rdata  out  8  read data
- m2  out  1  cartridge M2
- romsel  out  1  cartridge /ROMSEL
- cpu_rw  out  1  cartridge R/W
- cpu_addr  out  15  cartridge A14..A0
- cpu_data_out  out  8  driven data
- cpu_data_oe  out  1  data-pin output enable
- cpu_data_in  in  8  sampled data
- irq  in  1  cartridge /IRQ, active low
- irq_active  out  1  synchronised IRQ level

Function
REQ-005 SHALL run a two-phase machine, LOW then HIGH, repeating forever; a phase counter runs 0..M2_LOW_CLKS-1 in LOW and 0..M2_HIGH_CLKS-1 in HIGH.
REQ-006 SHALL register all outputs:
- m2=0 throughout LOW
- m2=1 throughout HIGH
REQ-007 SHALL assert req_ready only in the final clk of HIGH; a request is accepted when req_valid&&req_ready.
REQ-008 SHALL latch an accepted request on that edge and, from the first clk of the next LOW, drive the following for the whole cycle:
- cpu_addr=req_addr[14:0]
- cpu_rw=req_rw
REQ-009 SHALL drive romsel=0 during HIGH only when the latched address has bit 15 set and the cycle is a real request; otherwise romsel=1.
REQ-010 SHALL, for writes, drive cpu_data_out=req_wdata with cpu_data_oe=1 for all clks of HIGH; cpu_data_oe SHALL be 0 in every other clk.
REQ-011 SHALL sample cpu_data_in into rsp_rdata on the final clk of HIGH for reads; rsp_rdata SHALL hold its value otherwise.
REQ-012 SHALL pulse rsp_valid for exactly one clk, the first clk of the following LOW, for every real read or write cycle.
REQ-013 Latency: for a request accepted at clk T, rsp_valid SHALL be high at T+M2_LOW_CLKS+M2_HIGH_CLKS+1.
REQ-014 SHALL run a dummy cycle when no request is accepted:
- M2 keeps toggling
- cpu_rw=1
- cpu_addr held
- romsel=1
- no rsp_valid
REQ-015 Back-to-back requests SHALL be accepted one per bus cycle with no idle cycle between them.
REQ-016 Changes on req_* while not accepted SHALL have no effect.

Reset
REQ-017 While reset is high, SHALL hold:
- m2=0, romsel=1, cpu_rw=1
- cpu_addr=15'h7FFF
- cpu_data_oe=0, cpu_data_out=0
- req_ready=0, rsp_valid=0, rsp_rdata=0
- irq_active=0
- phase LOW, counter 0
REQ-018 Reset mid-cycle SHALL abort the cycle with no rsp_valid; the first cycle after reset release SHALL be a dummy cycle.

Configuration
REQ-019 Macro FAMICOM_BUS_MASTER_IRQ_SYNC_EN: when defined, irq SHALL pass through a two-flop synchroniser and irq_active=~synchronised irq, with a 2-clk latency.
REQ-020 Without FAMICOM_BUS_MASTER_IRQ_SYNC_EN, irq_active SHALL be constant 0 and irq SHALL be unused.

Structure
REQ-021 Package famicom_bus_pkg SHALL hold:
- phase enum (PH_LOW, PH_HIGH)
- default timing constants (6/6)
- reset address constant 15'h7FFF
REQ-022 The synchroniser SHALL be sub-module famicom_irq_sync, instantiated only under FAMICOM_BUS_MASTER_IRQ_SYNC_EN.
REQ-023 Parameter values below 2 SHALL raise an elaboration-time error.

Verification
REQ-024 Idle after reset, with defaults: m2 SHALL have a period of 12 clks at 50% duty, romsel=1, cpu_rw=1 and no rsp_valid.
REQ-025 Read $8123 with cpu_data_in=8'hA5 held:
- cpu_addr=15'h0123
- romsel=0 only during HIGH
- rsp_rdata=8'hA5 and rsp_valid at T+13
REQ-026 Write $6000=8'h3C:
- romsel=1, cpu_rw=0
- cpu_data_oe=1 for exactly 6 clks of HIGH with cpu_data_out=8'h3C
- rsp_valid at T+13
REQ-027 With req_valid held high, three consecutive reads SHALL give three rsp_valid pulses spaced 12 clks apart.
REQ-028 Reset asserted at clk 3 of the HIGH phase of a write SHALL drop m2/cpu_data_oe next clk, give no rsp_valid, and be followed by a dummy cycle.
REQ-029 With the macro defined, irq driven low SHALL set irq_active=1 two clks later; with the macro undefined, irq_active SHALL stay 0.
